// File: rtl/ysyx_2022040010_shift_ex.sv
// ysyx_2022040010_shift_ex: RV64 shift execute stage.
// Conditions the operands for the 64-bit and W-variant shifts and feeds the
// 64-bit barrel shifter. Results are held in a 2-entry in-order FIFO, so the
// stage has 1-cycle latency and runs at full throughput when out_ready is high.

module ysyx_2022040010_shift (
   input  logic [63:0] shift_src,
   input  logic [63:0] shift_amount,
   input  logic [2:0]  shift_op,
   output logic [63:0] shift_result
);
   logic [5:0] w_sh;
   logic       w_unused_amt;

   assign w_sh         = shift_amount[5:0];
   assign w_unused_amt = ^shift_amount[63:6];

   // One-hot op with priority SLL > SRL > SRA; no op selected gives 0
   always_comb begin
      shift_result = 64'd0;
      if (shift_op[2])      shift_result = shift_src << w_sh;
      else if (shift_op[1]) shift_result = shift_src >> w_sh;
      else if (shift_op[0]) shift_result = $signed(shift_src) >>> w_sh;
   end
endmodule

module ysyx_2022040010_shift_ex #(
   parameter int RD_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_op,
   input  logic            in_word,
   input  logic [63:0]     in_src1,
   input  logic [63:0]     in_src2,
   input  logic [RD_W-1:0] in_rd,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [63:0]     out_result,
   output logic [RD_W-1:0] out_rd
);
   logic        w_srl;
   logic        w_sra;
   logic [63:0] w_amt;
   logic [63:0] w_src;
   logic [63:0] w_shift_out;
   logic [63:0] w_res;
   logic        w_push;
   logic        w_pop;
   logic        w_unused_src2;

   logic [63:0]     r_res [2];
   logic [RD_W-1:0] r_rd  [2];
   logic            r_wptr;
   logic            r_rptr;
   logic [1:0]      r_count;

   // Decoded with the same priority as the shifter so the right source
   // conditioning is picked when several op bits are set.
   assign w_srl = ~in_op[2] & in_op[1];
   assign w_sra = (in_op == 3'b001);

   assign w_amt         = in_word ? {59'b0, in_src2[4:0]} : {58'b0, in_src2[5:0]};
   assign w_unused_src2 = ^in_src2[63:6];

   // Right shifts of a word must bring in zeros / the word's sign bit
   always_comb begin
      w_src = in_src1;
      if (in_word && w_srl)      w_src = {32'b0, in_src1[31:0]};
      else if (in_word && w_sra) w_src = {{32{in_src1[31]}}, in_src1[31:0]};
   end

   ysyx_2022040010_shift u_shift (
      .shift_src    (w_src),
      .shift_amount (w_amt),
      .shift_op     (in_op),
      .shift_result (w_shift_out)
   );

   assign w_res = in_word ? {{32{w_shift_out[31]}}, w_shift_out[31:0]} : w_shift_out;

   // Ready comes from registered count only; a full FIFO refuses even if it pops
   assign in_ready   = (r_count != 2'd2);
   assign out_valid  = (r_count != 2'd0);
   assign out_result = r_res[r_rptr];
   assign out_rd     = r_rd[r_rptr];

   assign w_push = in_valid & in_ready;
   assign w_pop  = out_valid & out_ready;

   // FIFO storage, pointers and occupancy; reset beats flush beats push/pop
   always_ff @(posedge clk) begin
      if (rst) begin
         r_res[0] <= 64'd0;
         r_res[1] <= 64'd0;
         r_rd[0]  <= '0;
         r_rd[1]  <= '0;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_count  <= 2'd0;
      end else if (flush) begin
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_push) begin
            r_res[r_wptr] <= w_res;
            r_rd[r_wptr]  <= in_rd;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) r_rptr <= ~r_rptr;
         if (w_push && !w_pop)      r_count <= r_count + 2'd1;
         else if (!w_push && w_pop) r_count <= r_count - 2'd1;
      end
   end
endmodule

// File: tb/tb_ysyx_2022040010_shift_ex.sv
// Bench for ysyx_2022040010_shift_ex: directed cases plus randomized traffic
// against a queue-based reference model.

module tb_ysyx_2022040010_shift_ex;
   localparam int RD_W = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      in_op;
   logic            in_word;
   logic [63:0]     in_src1;
   logic [63:0]     in_src2;
   logic [RD_W-1:0] in_rd;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [63:0]     out_result;
   logic [RD_W-1:0] out_rd;

   int n_chk = 0;
   int n_err = 0;

   logic [63:0]     q_res[$];
   logic [RD_W-1:0] q_rd[$];

   ysyx_2022040010_shift_ex #(.RD_W(RD_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_word    (in_word),
      .in_src1    (in_src1),
      .in_src2    (in_src2),
      .in_rd      (in_rd),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_rd     (out_rd)
   );

   always #5 clk = ~clk;

   // Behavioural shift: 32-bit arithmetic for W ops, then sign-extend
   function automatic logic [63:0] ref_shift(input logic [2:0] op, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
      int unsigned amt;
      logic [31:0] t32;
      logic [63:0] r;
      amt = w ? int'(b[4:0]) : int'(b[5:0]);
      t32 = 32'd0;
      r   = 64'd0;
      if (w) begin
         if (op[2])      t32 = a[31:0] << amt;
         else if (op[1]) t32 = a[31:0] >> amt;
         else if (op[0]) t32 = $signed(a[31:0]) >>> amt;
         r = {{32{t32[31]}}, t32};
      end else begin
         if (op[2])      r = a << amt;
         else if (op[1]) r = a >> amt;
         else if (op[0]) r = $signed(a) >>> amt;
      end
      return r;
   endfunction

   // One clock: model follows the edge using the inputs held across it
   task automatic cyc();
      logic push, pop;
      @(posedge clk);
      push = in_valid && (q_res.size() < 2);
      pop  = (q_res.size() != 0) && out_ready;
      if (rst || flush) begin
         q_res.delete();
         q_rd.delete();
      end else begin
         if (pop) begin
            void'(q_res.pop_front());
            void'(q_rd.pop_front());
         end
         if (push) begin
            q_res.push_back(ref_shift(in_op, in_word, in_src1, in_src2));
            q_rd.push_back(in_rd);
         end
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [RD_W-1:0] rd);
      in_valid = v;
      in_op    = op;
      in_word  = w;
      in_src1  = a;
      in_src2  = b;
      in_rd    = rd;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 3'b000, 1'b0, 64'd0, 64'd0, '0);
      cyc(); cyc();
      rst = 1'b0;
      n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      n_chk++; if (out_result !== 64'd0) begin n_err++; $display("FAIL reset_out_result got=%h exp=0", out_result); end
      n_chk++; if (out_rd !== '0) begin n_err++; $display("FAIL reset_out_rd got=%h exp=0", out_rd); end
   endtask

   task automatic test_directed();
      logic [2:0]  ops [6] = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b000, 3'b110};
      logic        ws  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [63:0] s1  [6] = '{64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000,
                               64'hFFFF_FFFF_8000_0000, 64'd1, 64'hDEAD_BEEF_1234_5678,
                               64'h0000_0000_0000_00F1};
      logic [63:0] s2  [6] = '{64'h44, 64'h21, 64'd31, 64'd31, 64'd3, 64'd4};
      logic [63:0] ex  [6] = '{64'hF800_0000_0000_0000, 64'hFFFF_FFFF_C000_0000,
                               64'h0000_0000_0000_0001, 64'hFFFF_FFFF_8000_0000, 64'd0,
                               64'h0000_0000_0000_0F10};
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, ops[i], ws[i], s1[i], s2[i], RD_W'(i + 7));
         cyc();
         drive(1'b0, 3'b000, 1'b0, 64'd0, 64'd0, '0);
         n_chk++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL dir%0d_valid got=%b exp=1", i, out_valid); end
         n_chk++; if (out_result !== ex[i]) begin n_err++; $display("FAIL dir%0d_result got=%h exp=%h", i, out_result, ex[i]); end
         n_chk++; if (out_rd !== RD_W'(i + 7)) begin n_err++; $display("FAIL dir%0d_rd got=%0d exp=%0d", i, out_rd, i + 7); end
         out_ready = 1'b1;
         cyc();
         out_ready = 1'b0;
         n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dir%0d_drain got=%b exp=0", i, out_valid); end
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      drive(1'b1, 3'b100, 1'b0, 64'd1, 64'd1, 5'd1); cyc();
      drive(1'b1, 3'b100, 1'b0, 64'd1, 64'd2, 5'd2); cyc();
      drive(1'b1, 3'b100, 1'b0, 64'd1, 64'd3, 5'd3);
      n_chk++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full_ready got=%b exp=0", in_ready); end
      cyc();
      n_chk++; if (out_rd !== 5'd1 || out_result !== 64'd2) begin n_err++; $display("FAIL b2b_stall_head got=rd%0d/%h exp=rd1/2", out_rd, out_result); end
      n_chk++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_stall_ready got=%b exp=0", in_ready); end
      out_ready = 1'b1;
      cyc();
      n_chk++; if (out_valid !== 1'b1 || out_rd !== 5'd2 || out_result !== 64'd4) begin n_err++; $display("FAIL b2b_second got=v%b rd%0d/%h exp=v1 rd2/4", out_valid, out_rd, out_result); end
      cyc();
      drive(1'b0, 3'b000, 1'b0, 64'd0, 64'd0, '0);
      n_chk++; if (out_valid !== 1'b1 || out_rd !== 5'd3 || out_result !== 64'd8) begin n_err++; $display("FAIL b2b_third got=v%b rd%0d/%h exp=v1 rd3/8", out_valid, out_rd, out_result); end
      cyc();
      n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
      out_ready = 1'b0;
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive(1'b1, 3'b010, 1'b0, 64'hFF, 64'd1, 5'd4); cyc();
      drive(1'b1, 3'b010, 1'b0, 64'hFF, 64'd2, 5'd5); cyc();
      drive(1'b1, 3'b010, 1'b0, 64'hFF, 64'd3, 5'd6);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      drive(1'b0, 3'b000, 1'b0, 64'd0, 64'd0, '0);
      n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
      n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
      out_ready = 1'b1;
      cyc();
      n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_nothing_left got=%b exp=0", out_valid); end
      drive(1'b1, 3'b100, 1'b0, 64'd3, 64'd0, 5'd9); cyc();
      drive(1'b0, 3'b000, 1'b0, 64'd0, 64'd0, '0);
      n_chk++; if (out_valid !== 1'b1 || out_rd !== 5'd9 || out_result !== 64'd3) begin n_err++; $display("FAIL flush_restart got=v%b rd%0d/%h exp=v1 rd9/3", out_valid, out_rd, out_result); end
      cyc();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      drive(1'b1, 3'b100, 1'b0, 64'h55, 64'd1, 5'd17); cyc();
      drive(1'b0, 3'b000, 1'b0, 64'd0, 64'd0, '0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_flags got=v%b r%b exp=v0 r1", out_valid, in_ready); end
      n_chk++; if (out_result !== 64'd0 || out_rd !== '0) begin n_err++; $display("FAIL rstmid_data got=%h/%0d exp=0/0", out_result, out_rd); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 1'($urandom),
               {$urandom, $urandom}, {$urandom, $urandom}, RD_W'($urandom));
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         rst       = ($urandom_range(0, 99) == 0);
         cyc();
         n_chk++; if (out_valid !== (q_res.size() != 0)) begin n_err++; $display("FAIL rnd%0d_valid got=%b exp=%b", i, out_valid, q_res.size() != 0); end
         n_chk++; if (in_ready !== (q_res.size() < 2)) begin n_err++; $display("FAIL rnd%0d_ready got=%b exp=%b", i, in_ready, q_res.size() < 2); end
         if (q_res.size() != 0) begin
            n_chk++; if (out_result !== q_res[0]) begin n_err++; $display("FAIL rnd%0d_result got=%h exp=%h", i, out_result, q_res[0]); end
            n_chk++; if (out_rd !== q_rd[0]) begin n_err++; $display("FAIL rnd%0d_rd got=%0d exp=%0d", i, out_rd, q_rd[0]); end
         end
      end
      rst = 1'b0; flush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/ysyx_2022040010_shift_ex.md
YSYX_2022040010_SHIFT_EX -- requirements
Module: ysyx_2022040010_shift_ex

Interface
REQ-001 Parameter: RD_W, default 5, width of the destination-register tag carried alongside each shift.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream (ID/EX) presents a shift operation.
REQ-005 in_ready  output  1  block can accept an operation this cycle.
REQ-006 in_op  input  3  one-hot operation: bit2 SLL, bit1 SRL, bit0 SRA.
REQ-007 in_word  input  1  1 = RV64 W-variant (SLLW/SRLW/SRAW).
REQ-008 in_src1  input  64  value to be shifted.
REQ-009 in_src2  input  64  shift-amount operand (register or immediate, unmasked).
REQ-010 in_rd  input  RD_W  destination tag, passed through unchanged.
REQ-011 flush  input  1  discard all held and incoming operations.
REQ-012 out_valid  output  1  result available to downstream (EX/MEM).
REQ-013 out_ready  input  1  downstream accepts the result this cycle.
REQ-014 out_result  output  64  final 64-bit shift result.
REQ-015 out_rd  output  RD_W  tag of the result on out_result.

Function
REQ-016 The block SHALL instantiate ysyx_2022040010_shift and drive its shift_src, shift_amount and shift_op inputs combinationally from the in_* ports.
REQ-017 Amount masking SHALL be: in_word=0 -> {58'b0, in_src2[5:0]}; in_word=1 -> {59'b0, in_src2[4:0]}; upper in_src2 bits SHALL never reach the shifter.
REQ-018 Source conditioning for word ops SHALL be: SLLW -> in_src1 unchanged; SRLW -> {32'b0, in_src1[31:0]}; SRAW -> {{32{in_src1[31]}}, in_src1[31:0]}; non-word ops -> in_src1 unchanged.
REQ-019 Result SHALL be: in_word=0 -> shifter output; in_word=1 -> sign-extension of shifter output bits [31:0] to 64 bits.
REQ-020 in_op decoding SHALL use priority SLL > SRL > SRA when more than one bit is set; in_op=000 SHALL produce result 0 (including the word case).
REQ-021 Results SHALL be written, with in_rd, into a 2-entry in-order FIFO; an operation is accepted when in_valid && in_ready.
REQ-022 Latency SHALL be 1 cycle: an operation accepted in cycle N with the FIFO empty SHALL appear on out_* with out_valid=1 in cycle N+1.
REQ-023 in_ready SHALL equal (count < 2), registered-state only; an accept SHALL NOT be allowed when count=2 even if a pop occurs in the same cycle.
REQ-024 A pop occurs when out_valid && out_ready; simultaneous push and pop with count=1 SHALL leave count=1 with the new entry at the head in the next cycle.
REQ-025 out_valid SHALL equal (count != 0); out_result/out_rd SHALL show the head entry and SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 Read/write pointers SHALL wrap modulo 2; throughput SHALL be one operation per cycle when out_ready is held at 1.
REQ-027 flush=1 SHALL, in the next cycle, set count=0 and both pointers to 0; an accept or pop in the flush cycle SHALL be discarded.
REQ-028 in_ready, out_valid, out_result and out_rd SHALL not depend combinationally on in_valid, out_ready or flush.

Reset
REQ-029 rst=1 SHALL, at the next rising edge, set count=0, pointers=0 and both FIFO entries (result and tag) to 0, giving out_valid=0, out_result=0, out_rd=0, in_ready=1.
REQ-030 rst SHALL take priority over flush, accept and pop; reset asserted mid-stream SHALL drop all held entries.

Verification
REQ-031 SRA, word=0, src1=0x8000_0000_0000_0000, src2=0x44 -> out_result 0xF800_0000_0000_0000 one cycle after accept (amount masked to 4).
REQ-032 SRAW, src1=0x0000_0000_8000_0000, src2=0x21 -> 0xFFFF_FFFF_C000_0000; SRLW, src1=0xFFFF_FFFF_8000_0000, src2=31 -> 0x0000_0000_0000_0001; SLLW, src1=1, src2=31 -> 0xFFFF_FFFF_8000_0000.
REQ-033 out_ready=0, three back-to-back in_valid ops (rd 1,2,3) -> in_ready=0 after two accepts, op rd=3 stalls; raise out_ready -> results emerge in order rd 1,2,3, one per cycle.
REQ-034 count=2 with in_valid=1 and flush=1 in the same cycle -> next cycle out_valid=0, in_ready=1; neither the held nor the incoming op ever appears.
REQ-035 in_op=000 with in_valid=1 -> an entry with out_result=0 and out_rd=in_rd; in_op=110 -> SLL result.
REQ-036 rst=1 while count=1 and out_ready=0 -> next cycle out_valid=0, out_result=0, out_rd=0, in_ready=1.
